// File: rtl/segment_pkg.sv
// segment_pkg
//   Shared constants and types for the 7-segment observer. This package holds
//   the decimal segment patterns (bits a..g, with a in the MSB), the one-hot-low
//   common-select codes with the decimal point expected at each digit
//   position, and the capture FSM state type.
package segment_pkg;

  // Segment patterns {a,b,c,d,e,f,g} for the decimal digits
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  // Common-select codes (one-hot-low); all-ones means the display is blanked
  localparam logic [3:0] COM_D0    = 4'b0111;
  localparam logic [3:0] COM_D1    = 4'b1011;
  localparam logic [3:0] COM_D2    = 4'b1101;
  localparam logic [3:0] COM_D3    = 4'b1110;
  localparam logic [3:0] COM_BLANK = 4'b1111;

  // Decimal point the driver shows at each digit position
  localparam logic DP_D0 = 1'b0;
  localparam logic DP_D1 = 1'b1;
  localparam logic DP_D2 = 1'b0;
  localparam logic DP_D3 = 1'b1;

  typedef enum logic {
    HUNT = 1'b0,
    CAPT = 1'b1
  } cap_state_t;

endpackage

// File: rtl/segment_bcd.sv
// segment_bcd
//   Combinational decoder from a 7-segment pattern back to a BCD nibble. It is
//   the inverse of the display driver's encoder.
//   Ports:
//     pattern  in  7  segment bits {a,b,c,d,e,f,g}
//     nibble   out 4  decoded digit (0 when the pattern is not a digit)
//     valid    out 1  pattern is one of the ten decimal digits
module segment_bcd
  import segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'd0;
    valid  = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'd0;
      SEG_1:   nibble = 4'd1;
      SEG_2:   nibble = 4'd2;
      SEG_3:   nibble = 4'd3;
      SEG_4:   nibble = 4'd4;
      SEG_5:   nibble = 4'd5;
      SEG_6:   nibble = 4'd6;
      SEG_7:   nibble = 4'd7;
      SEG_8:   nibble = 4'd8;
      SEG_9:   nibble = 4'd9;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_capture.sv
// segment_capture
//   Watches a multiplexed 4-digit 7-segment display bus and rebuilds the BCD
//   word that is being shown. It publishes the word once the same value has
//   been seen for STABLE_FRAMES complete frames in a row.
//   Parameters:
//     STABLE_FRAMES  identical consecutive frames needed before publishing (1..15)
//     CHECK_DOT      when set, the decimal point must match its position
//   Ports:
//     clk         in   1   system clock
//     reset       in   1   asynchronous, active-low
//     com         in   4   common-select lines, one-hot-low
//     arraydata   in   8   segment lines {a,b,c,d,e,f,g,dp}
//     data_out    out  16  last published word, digit0 in [15:12]
//     data_valid  out  1   one-cycle pulse when data_out is updated
//     locked      out  1   stream is currently stable
//     err         out  1   one-cycle pulse when a frame is aborted
module segment_capture
  import segment_pkg::*;
#(
  parameter int STABLE_FRAMES = 2,
  parameter bit CHECK_DOT     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  com,
  input  logic [7:0]  arraydata,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        locked,
  output logic        err
);

  localparam logic [3:0] STABLE_TGT = 4'(STABLE_FRAMES);

  logic [3:0]  com_q;
  logic [7:0]  data_q;

  logic [1:0]  pos;
  logic        exp_dp;
  logic        is_digit;
  logic        is_blank;
  logic        is_illegal;
  logic [3:0]  nibble;
  logic        pat_valid;
  logic        dp_ok;

  cap_state_t  state, state_n;
  logic [1:0]  exp_digit, exp_digit_n;
  logic [11:0] shadow, shadow_n;
  logic [3:0]  last_com, last_com_n;
  logic [7:0]  last_data, last_data_n;
  logic        done_q, done_n;
  logic [15:0] word_q, word_n;
  logic        abort;
  logic        err_n;

  logic [15:0] last_word;
  logic [3:0]  stable_cnt;

  // The bus is registered once so every decision looks at one consistent sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      com_q  <= COM_BLANK;
      data_q <= 8'h00;
    end else begin
      com_q  <= com;
      data_q <= arraydata;
    end
  end

  // Map the sampled common lines to a digit position and its expected dp
  always_comb begin
    pos      = 2'd0;
    exp_dp   = 1'b0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (com_q)
      COM_D0: begin pos = 2'd0; exp_dp = DP_D0; end
      COM_D1: begin pos = 2'd1; exp_dp = DP_D1; end
      COM_D2: begin pos = 2'd2; exp_dp = DP_D2; end
      COM_D3: begin pos = 2'd3; exp_dp = DP_D3; end
      COM_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

  assign is_illegal = !is_digit && !is_blank;
  assign dp_ok      = !CHECK_DOT || (data_q[0] == exp_dp);

  segment_bcd u_bcd (
    .pattern (data_q[7:1]),
    .nibble  (nibble),
    .valid   (pat_valid)
  );

  // Capture FSM registers; done_q/word_q hand a finished frame to the
  // stability stage one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      exp_digit <= 2'd0;
      shadow    <= 12'h000;
      last_com  <= COM_BLANK;
      last_data <= 8'h00;
      done_q    <= 1'b0;
      word_q    <= 16'h0000;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      exp_digit <= exp_digit_n;
      shadow    <= shadow_n;
      last_com  <= last_com_n;
      last_data <= last_data_n;
      done_q    <= done_n;
      word_q    <= word_n;
      err       <= err_n;
    end
  end

  // Next-state logic. A repeat of the last accepted digit with identical
  // segments is the driver dwelling and is ignored; a repeat with different
  // segments means the bus changed under us and kills the frame.
  always_comb begin
    state_n     = state;
    exp_digit_n = exp_digit;
    shadow_n    = shadow;
    last_com_n  = last_com;
    last_data_n = last_data;
    done_n      = 1'b0;
    word_n      = word_q;
    abort       = 1'b0;
    err_n       = 1'b0;
    case (state)
      HUNT: begin
        if (is_illegal || (is_digit && !pat_valid)) begin
          err_n = 1'b1;
        end else if (is_digit && pos == 2'd0 && dp_ok) begin
          shadow_n    = {nibble, 8'h00};
          exp_digit_n = 2'd1;
          last_com_n  = com_q;
          last_data_n = data_q;
          state_n     = CAPT;
        end
      end
      CAPT: begin
        if (is_blank) begin
          state_n = CAPT;
        end else if (is_illegal) begin
          abort = 1'b1;
        end else if (com_q == last_com) begin
          abort = (data_q != last_data);
        end else if (!pat_valid || !dp_ok || pos != exp_digit) begin
          abort = 1'b1;
        end else begin
          last_com_n  = com_q;
          last_data_n = data_q;
          exp_digit_n = exp_digit + 2'd1;
          case (pos)
            2'd1: shadow_n[7:4] = nibble;
            2'd2: shadow_n[3:0] = nibble;
            default: begin
              done_n  = 1'b1;
              word_n  = {shadow, nibble};
              state_n = HUNT;
            end
          endcase
        end
        if (abort) begin
          err_n       = 1'b1;
          state_n     = HUNT;
          exp_digit_n = 2'd0;
          shadow_n    = 12'h000;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Stability tracking: count identical completed frames and publish on the
  // completion that first reaches the target count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= 16'h0000;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      last_word  <= 16'h0000;
      stable_cnt <= 4'd0;
    end else begin
      data_valid <= 1'b0;
      if (abort) begin
        stable_cnt <= 4'd0;
        locked     <= 1'b0;
      end else if (done_q) begin
        if (word_q == last_word) begin
          if (stable_cnt < STABLE_TGT) begin
            stable_cnt <= stable_cnt + 4'd1;
            if (stable_cnt + 4'd1 == STABLE_TGT) begin
              data_out   <= word_q;
              data_valid <= 1'b1;
              locked     <= 1'b1;
            end
          end
        end else begin
          last_word  <= word_q;
          stable_cnt <= 4'd1;
          if (STABLE_TGT == 4'd1) begin
            data_out   <= word_q;
            data_valid <= 1'b1;
            locked     <= 1'b1;
          end else begin
            locked <= 1'b0;
          end
        end
      end
    end
  end

endmodule
